sr_latch_driver: RTL and testbench

- Upstream control stage for the NAND SR latch. It conditions two raw pushbutton/switch inputs, set_btn and reset_btn.
- Synchronizes and debounces each input, detects the rising edge, and issues registered active-low pulses on sbar/rbar that feed the latch's Sbar/Rbar inputs directly.
- Guarantees the latch never sees the forbidden state (both inputs low) and never sees a glitch.

---
 rtl/sr_ctrl_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/sr_latch_driver.sv | 119 +++++++++++
 tb/tb_sr_latch_driver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR latch driver: FSM states, default timing
// constants and the counter-width helper.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2,
    GAP   = 2'd3
  } sr_state_e;

  localparam int unsigned DEB_CYC   = 4;
  localparam int unsigned PULSE_CYC = 2;
  localparam int unsigned GAP_CYC   = 1;

  // Bits needed for a counter that must reach max(a,b,c)-1; never below 1.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One input channel: 2-flop synchronizer, stability counter and a one-cycle
// strobe on the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);
  import sr_ctrl_pkg::*;

  localparam int unsigned CW = cnt_width(DEB_CYC, 1, 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchronize, then accept a new level only after DEB_CYC consecutive
  // cycles of disagreement with the current debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Strobe is formed from two registers, so it is glitch-free per cycle.
  assign rise = level & ~level_d;

endmodule

// File: rtl/sr_latch_driver.sv
// Conditions set/reset pushbuttons into non-overlapping active-low pulses
// for a NAND SR latch, with reset taking priority and a guard gap between
// pulses.
module sr_latch_driver #(
  parameter int unsigned DEB_CYC   = 4,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic sbar,
  output logic rbar,
  output logic busy
);
  import sr_ctrl_pkg::*;

  localparam int unsigned CW = cnt_width(DEB_CYC, PULSE_CYC, GAP_CYC);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

  logic          rise_s;
  logic          rise_r;
  logic          pend_s;
  logic          pend_r;
  logic          take_s;
  logic          take_r;
  logic          arb;
  sr_state_e     state;
  sr_state_e     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_s (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (set_btn),
    .rise  (rise_s)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_r (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (reset_btn),
    .rise  (rise_r)
  );

  // Next-state logic. The end of GAP arbitrates directly, exactly as IDLE
  // would, so a queued request starts on the edge that would enter IDLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take_s   = 1'b0;
    take_r   = 1'b0;
    arb      = 1'b0;
    case (state)
      IDLE: arb = 1'b1;
      SET_P, RST_P: begin
        if (cnt == PULSE_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          arb      = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (arb) begin
      if (pend_r || rise_r) begin
        state_nx = RST_P;
        cnt_nx   = '0;
        take_r   = 1'b1;
      end else if (pend_s || rise_s) begin
        state_nx = SET_P;
        cnt_nx   = '0;
        take_s   = 1'b1;
      end
    end
  end

  // FSM registers; outputs decoded from next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sbar  <= 1'b1;
      rbar  <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sbar  <= (state_nx != SET_P);
      rbar  <= (state_nx != RST_P);
      busy  <= (state_nx != IDLE);
    end
  end

  // Pending flags: set by strobe, merged on repeat, cleared when served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_s <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      pend_s <= (pend_s | rise_s) & ~take_s;
      pend_r <= (pend_r | rise_r) & ~take_r;
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed scenarios plus random button activity,
// checked cycle by cycle against a timeline model of the driver.
module tb_sr_latch_driver;

  localparam int DEB = 4;
  localparam int PUL = 2;
  localparam int GAPC = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_btn = 1'b0;
  logic reset_btn = 1'b0;
  logic sbar;
  logic rbar;
  logic busy;

  int tests = 0;
  int fails = 0;

  sr_latch_driver #(.DEB_CYC(DEB), .PULSE_CYC(PUL), .GAP_CYC(GAPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_btn   (set_btn),
    .reset_btn (reset_btn),
    .sbar      (sbar),
    .rbar      (rbar),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: raw sample history, debounced levels, pending requests
  // and the scheduled pulse windows expressed as edge-number intervals.
  int now;
  int free_at, busy_end, s_start, s_end, r_start, r_end;
  bit m_pend_s, m_pend_r, m_deb_s, m_deb_r;
  bit hist_s[$];
  bit hist_r[$];
  bit exp_sbar, exp_rbar, exp_busy;

  // Scenario statistics and a behavioural NAND latch fed by the DUT.
  int cnt_s_low, cnt_r_low, cnt_busy, first_s, first_r;
  bit q;

  function automatic bit window_differs(input bit h[$], input int n, input bit d);
    for (int j = 0; j < DEB; j++) begin
      int idx;
      bit v;
      idx = n - 2 - j;
      v = (idx >= 0) ? h[idx] : 1'b0;
      if (v == d) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    now = 0; free_at = 0; busy_end = 0;
    s_start = 0; s_end = 0; r_start = 0; r_end = 0;
    m_pend_s = 0; m_pend_r = 0; m_deb_s = 0; m_deb_r = 0;
    hist_s.delete(); hist_r.delete();
    cnt_s_low = 0; cnt_r_low = 0; cnt_busy = 0; first_s = -1; first_r = -1;
    q = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit r);
    if (now >= free_at && (m_pend_r || m_pend_s)) begin
      if (m_pend_r) begin
        r_start = now; r_end = now + PUL; m_pend_r = 0;
      end else begin
        s_start = now; s_end = now + PUL; m_pend_s = 0;
      end
      busy_end = now + PUL + GAPC;
      free_at = busy_end;
    end
    hist_s.push_back(s);
    hist_r.push_back(r);
    if (window_differs(hist_s, now, m_deb_s)) begin
      m_deb_s = ~m_deb_s;
      if (m_deb_s) m_pend_s = 1;
    end
    if (window_differs(hist_r, now, m_deb_r)) begin
      m_deb_r = ~m_deb_r;
      if (m_deb_r) m_pend_r = 1;
    end
    exp_sbar = !(now >= s_start && now < s_end);
    exp_rbar = !(now >= r_start && now < r_end);
    exp_busy = (now < busy_end);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, now, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_no_overlap();
    tests++;
    assert (!(sbar === 1'b0 && rbar === 1'b0)) else begin
      fails++;
      $error("FAIL overlap at edge %0d: observed sbar=%b rbar=%b expected not both 0", now, sbar, rbar);
    end
  endtask

  // One clock: drive raw inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit s, input bit r);
    set_btn = s;
    reset_btn = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    check("sbar", sbar, exp_sbar);
    check("rbar", rbar, exp_rbar);
    check("busy", busy, exp_busy);
    check_no_overlap();
    if (sbar === 1'b0) begin
      cnt_s_low++;
      if (first_s < 0) first_s = now;
    end
    if (rbar === 1'b0) begin
      cnt_r_low++;
      if (first_r < 0) first_r = now;
    end
    if (busy === 1'b1) cnt_busy++;
    if (sbar === 1'b0) q = 1'b1;
    else if (rbar === 1'b0) q = 1'b0;
    now++;
  endtask

  task automatic repeat_step(input int n, input bit s, input bit r);
    for (int i = 0; i < n; i++) step(s, r);
  endtask

  // Hold reset for three edges with inputs toggling, then release mid-cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_btn = 1'($urandom);
      reset_btn = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_sbar", sbar, 1'b1);
      check("rst_rbar", rbar, 1'b1);
      check("rst_busy", busy, 1'b0);
    end
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int rs_len, rr_len;
    bit vs, vr;

    model_reset();
    do_reset();

    // Clean set press
    repeat_step(10, 1, 0);
    repeat_step(12, 0, 0);
    check_int("clean_first_s", first_s, 6);
    check_int("clean_s_low", cnt_s_low, 2);
    check_int("clean_r_low", cnt_r_low, 0);
    check_int("clean_busy", cnt_busy, 3);
    check_int("clean_q", int'(q), 1);

    // Bounce rejection
    do_reset();
    repeat_step(3, 1, 0);
    repeat_step(1, 0, 0);
    repeat_step(2, 1, 0);
    repeat_step(14, 0, 0);
    check_int("bounce_s_low", cnt_s_low, 0);
    check_int("bounce_busy", cnt_busy, 0);

    // Simultaneous set and reset
    do_reset();
    repeat_step(12, 1, 1);
    repeat_step(10, 0, 0);
    check_int("simul_first_r", first_r, 6);
    check_int("simul_first_s", first_s, 9);
    check_int("simul_s_low", cnt_s_low, 2);
    check_int("simul_r_low", cnt_r_low, 2);
    check_int("simul_q", int'(q), 1);

    // Reset request queued behind a set pulse
    do_reset();
    repeat_step(2, 1, 0);
    repeat_step(10, 1, 1);
    repeat_step(12, 0, 0);
    check_int("queue_first_s", first_s, 6);
    check_int("queue_first_r", first_r, 9);
    check_int("queue_q", int'(q), 0);

    // Long hold then release: one pulse only
    do_reset();
    repeat_step(50, 1, 0);
    repeat_step(20, 0, 0);
    check_int("hold_s_low", cnt_s_low, 2);
    check_int("hold_r_low", cnt_r_low, 0);

    // Asynchronous reset in the middle of a set pulse
    do_reset();
    repeat_step(7, 1, 0);
    check_int("async_pre_s_low", cnt_s_low, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_sbar", sbar, 1'b1);
    check("async_rbar", rbar, 1'b1);
    check("async_busy", busy, 1'b0);
    do_reset();

    // Random button activity with mixed bounce and hold lengths
    rs_len = 0;
    rr_len = 0;
    vs = 0;
    vr = 0;
    for (int c = 0; c < 800; c++) begin
      if (rs_len == 0) begin
        vs = 1'($urandom);
        rs_len = int'($urandom_range(1, 9));
      end
      if (rr_len == 0) begin
        vr = 1'($urandom);
        rr_len = int'($urandom_range(1, 9));
      end
      step(vs, vr);
      rs_len--;
      rr_len--;
    end
    repeat_step(15, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
